// File: rtl/usb_reg_master_pkg.sv
// Shared types and defaults for the Wishbone-to-USB register-port initiator.
package usb_reg_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          TMO_CYCLES_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF   = 32'hDEAD_0BAD;
  localparam int          ERR_CNT_W      = 8;

endpackage

// File: rtl/usb_reg_master.sv
// Wishbone-classic slave that turns each cycle into one held register request
// on the USB core register port, with a no-ack timeout and saturating error count.
module usb_reg_master
  import usb_reg_master_pkg::*;
#(
  parameter int            AW         = 11,
  parameter int            DW         = 32,
  parameter int            TMO_CYCLES = TMO_CYCLES_DEF,
  parameter logic [DW-1:0] ERR_DATA   = DW'(ERR_DATA_DEF)
) (
  input  logic                 app_clk,
  input  logic                 reset_ssn,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [AW-1:0]        wbs_adr_i,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic [DW/8-1:0]      wbs_sel_i,
  output logic [DW-1:0]        wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 reg_cs,
  output logic                 reg_wr,
  output logic [AW-1:0]        reg_addr,
  output logic [DW-1:0]        reg_wdata,
  output logic [DW/8-1:0]      reg_be,
  input  logic [DW-1:0]        reg_rdata,
  input  logic                 reg_ack,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int            TW       = $clog2(TMO_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   abort_q, abort_d;
  logic                   reg_cs_q, reg_cs_d;
  logic                   reg_wr_q, reg_wr_d;
  logic [AW-1:0]          reg_addr_q, reg_addr_d;
  logic [DW-1:0]          reg_wdata_q, reg_wdata_d;
  logic [DW/8-1:0]        reg_be_q, reg_be_d;
  logic [DW-1:0]          dat_q, dat_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    abort_d     = abort_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    dat_d       = dat_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          reg_wr_d    = wbs_we_i;
          reg_addr_d  = wbs_adr_i;
          reg_wdata_d = wbs_dat_i;
          reg_be_d    = wbs_sel_i;
          reg_cs_d    = 1'b1;
          timer_d     = '0;
          abort_d     = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A master abort only silences the Wishbone response; the register
        // transaction itself always completes so the target is never left mid-access.
        abort_d = abort_q | ~wbs_cyc_i;
        if (reg_ack) begin
          reg_cs_d = 1'b0;
          state_d  = DONE;
          if (!abort_d) begin
            ack_d = 1'b1;
            dat_d = reg_wr_q ? '0 : reg_rdata;
          end
        end else if (timer_q == TMO_LAST) begin
          reg_cs_d = 1'b0;
          state_d  = DONE;
          if (!abort_d) begin
            err_d = 1'b1;
            dat_d = ERR_DATA;
          end
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!reset_ssn) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      abort_q     <= 1'b0;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
      dat_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      abort_q     <= abort_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      dat_q       <= dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign reg_cs    = reg_cs_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;
  assign err_cnt   = err_cnt_q;

endmodule
